// File: rtl/data_mem_unit.sv
// Byte-serial load/store unit: splits a byte/half/word request into single-byte
// transfers on the memory controller LSB port and assembles the one response.
module data_mem_unit #(
  parameter int TAG_W = 4
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_wr,
  input  logic [31:0]      req_addr,
  input  logic [1:0]       req_size,
  input  logic             req_signed,
  input  logic [31:0]      req_wdata,
  input  logic [TAG_W-1:0] req_tag,
  input  logic             flush,
  output logic             resp_valid,
  output logic [31:0]      resp_data,
  output logic [TAG_W-1:0] resp_tag,
  output logic [31:0]      lsb_addr,
  output logic [7:0]       lsb_data,
  output logic             lsb_wr,
  output logic             lsb_en,
  input  logic [7:0]       lsb_read_data,
  input  logic             lsb_valid
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t           state_q, state_d;
  logic [2:0]       issue_cnt_q, issue_cnt_d;
  logic [2:0]       recv_cnt_q, recv_cnt_d;

  logic [31:0]      addr_q;
  logic [31:0]      wdata_q;
  logic [31:0]      result_q;
  logic [2:0]       n_q;
  logic             signed_q;
  logic             wr_q;
  logic [TAG_W-1:0] tag_q;

  logic accept, issue, recv;

  function automatic logic [2:0] size_to_bytes(input logic [1:0] size);
    logic [2:0] n;
    case (size)
      2'b00:   n = 3'd1;
      2'b01:   n = 3'd2;
      default: n = 3'd4;
    endcase
    return n;
  endfunction

  function automatic logic [31:0] extend_load(input logic [31:0] raw,
                                              input logic [2:0]  n,
                                              input logic        sgn);
    logic [31:0] r;
    case (n)
      3'd1:    r = {{24{sgn & raw[7]}}, raw[7:0]};
      3'd2:    r = {{16{sgn & raw[15]}}, raw[15:0]};
      default: r = raw;
    endcase
    return r;
  endfunction

  assign accept = (state_q == IDLE) && req_valid && !flush;
  assign issue  = (state_q == ACCESS) && (issue_cnt_q < n_q);
  assign recv   = (state_q == ACCESS) && lsb_valid && (recv_cnt_q < n_q);

  always_comb begin
    state_d     = state_q;
    issue_cnt_d = issue_cnt_q;
    recv_cnt_d  = recv_cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d     = ACCESS;
          issue_cnt_d = 3'd0;
          recv_cnt_d  = 3'd0;
        end
      end
      ACCESS: begin
        if (issue) issue_cnt_d = issue_cnt_q + 3'd1;
        if (recv)  recv_cnt_d  = recv_cnt_q + 3'd1;
        // Only loads are abortable; a store always runs to completion.
        if (flush && !wr_q)
          state_d = IDLE;
        else if (recv && (recv_cnt_q == (n_q - 3'd1)))
          state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q     <= IDLE;
      issue_cnt_q <= 3'd0;
      recv_cnt_q  <= 3'd0;
    end else begin
      state_q     <= state_d;
      issue_cnt_q <= issue_cnt_d;
      recv_cnt_q  <= recv_cnt_d;
    end
  end

  // Request payload and assembled load bytes; gated by state, so no reset needed.
  always_ff @(posedge clk_in) begin
    if (accept) begin
      addr_q   <= req_addr;
      wdata_q  <= req_wdata;
      n_q      <= size_to_bytes(req_size);
      signed_q <= req_signed;
      wr_q     <= req_wr;
      tag_q    <= req_tag;
    end
    if (recv && !wr_q)
      result_q[{recv_cnt_q[1:0], 3'b000} +: 8] <= lsb_read_data;
  end

  assign req_ready  = (state_q == IDLE);
  assign lsb_en     = issue;
  assign lsb_wr     = issue & wr_q;
  assign lsb_addr   = issue ? (addr_q + {29'd0, issue_cnt_q}) : 32'd0;
  assign lsb_data   = issue ? wdata_q[{issue_cnt_q[1:0], 3'b000} +: 8] : 8'd0;

  assign resp_valid = (state_q == DONE);
  assign resp_data  = ((state_q == DONE) && !wr_q) ? extend_load(result_q, n_q, signed_q) : 32'd0;
  assign resp_tag   = (state_q == DONE) ? tag_q : '0;

endmodule

// File: tb/tb_data_mem_unit.sv
// Directed bench for data_mem_unit with a one-cycle-latency byte memory model.
module tb_data_mem_unit;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        req_valid, req_ready, req_wr, req_signed, flush;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic [3:0]  req_tag;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic [3:0]  resp_tag;
  logic [31:0] lsb_addr;
  logic [7:0]  lsb_data;
  logic        lsb_wr, lsb_en;
  logic [7:0]  lsb_read_data;
  logic        lsb_valid;

  int vectors = 0;
  int miscompares = 0;

  data_mem_unit #(.TAG_W(4)) dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_wr(req_wr), .req_addr(req_addr), .req_size(req_size),
    .req_signed(req_signed), .req_wdata(req_wdata), .req_tag(req_tag),
    .flush(flush),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_tag(resp_tag),
    .lsb_addr(lsb_addr), .lsb_data(lsb_data), .lsb_wr(lsb_wr), .lsb_en(lsb_en),
    .lsb_read_data(lsb_read_data), .lsb_valid(lsb_valid)
  );

  always #5 clk_in = ~clk_in;

  function automatic logic [7:0] rom(input logic [31:0] a);
    case (a)
      32'h0000_1000: return 8'h11;
      32'h0000_1001: return 8'h22;
      32'h0000_1002: return 8'h33;
      32'h0000_1003: return 8'h44;
      32'h0000_0080: return 8'h80;
      32'h0000_0300: return 8'h34;
      32'h0000_0301: return 8'h92;
      32'hFFFF_FFFE: return 8'hAA;
      32'hFFFF_FFFF: return 8'hBB;
      32'h0000_0000: return 8'hCC;
      32'h0000_0001: return 8'hDD;
      default:       return 8'h5A;
    endcase
  endfunction

  // Memory answers every issued byte exactly one cycle later.
  always @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      lsb_valid     <= 1'b0;
      lsb_read_data <= 8'h00;
    end else begin
      lsb_valid     <= lsb_en;
      lsb_read_data <= rom(lsb_addr);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic request(input logic wr, input logic [31:0] a, input logic [1:0] sz,
                         input logic sg, input logic [31:0] wd, input logic [3:0] tg);
    req_valid = 1'b1; req_wr = wr; req_addr = a; req_size = sz;
    req_signed = sg; req_wdata = wd; req_tag = tg;
    chk("ready_c0", {31'd0, req_ready}, 32'd1);
    tick();
    req_valid = 1'b0;
  endtask

  // Runs issue cycles 1..n through acceptance of the next request at n+3.
  task automatic txn(input logic wr, input logic [31:0] a, input logic [1:0] sz,
                     input logic sg, input logic [31:0] wd, input logic [3:0] tg,
                     input int n, input logic [31:0] exp);
    request(wr, a, sz, sg, wd, tg);
    for (int k = 0; k < n; k++) begin
      chk("issue_en", {31'd0, lsb_en}, 32'd1);
      chk("issue_addr", lsb_addr, a + 32'(k));
      chk("issue_wr", {31'd0, lsb_wr}, {31'd0, wr});
      if (wr) chk("issue_data", {24'd0, lsb_data}, {24'd0, wd[8*k +: 8]});
      chk("ready_busy", {31'd0, req_ready}, 32'd0);
      tick();
    end
    chk("idle_en", {31'd0, lsb_en}, 32'd0);
    chk("idle_addr", lsb_addr, 32'd0);
    chk("early_resp", {31'd0, resp_valid}, 32'd0);
    tick();
    chk("resp_valid", {31'd0, resp_valid}, 32'd1);
    chk("resp_data", resp_data, exp);
    chk("resp_tag", {28'd0, resp_tag}, {28'd0, tg});
    tick();
    chk("resp_clear", {31'd0, resp_valid}, 32'd0);
    chk("resp_data0", resp_data, 32'd0);
    chk("ready_back", {31'd0, req_ready}, 32'd1);
  endtask

  initial begin
    rst_in = 1'b1; req_valid = 1'b0; req_wr = 1'b0; req_addr = '0; req_size = '0;
    req_signed = 1'b0; req_wdata = '0; req_tag = '0; flush = 1'b0;
    #1;
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_resp", {31'd0, resp_valid}, 32'd0);
    chk("rst_rdata", resp_data, 32'd0);
    chk("rst_rtag", {28'd0, resp_tag}, 32'd0);
    chk("rst_en", {31'd0, lsb_en}, 32'd0);
    chk("rst_wr", {31'd0, lsb_wr}, 32'd0);
    chk("rst_addr", lsb_addr, 32'd0);
    chk("rst_data", {24'd0, lsb_data}, 32'd0);
    tick(); tick();
    rst_in = 1'b0;
    tick();

    // Word load, byte loads signed/unsigned, signed half load, wrapping word load.
    txn(1'b0, 32'h0000_1000, 2'b10, 1'b0, 32'h0, 4'h3, 4, 32'h4433_2211);
    txn(1'b0, 32'h0000_0080, 2'b00, 1'b1, 32'h0, 4'h5, 1, 32'hFFFF_FF80);
    txn(1'b0, 32'h0000_0080, 2'b00, 1'b0, 32'h0, 4'h6, 1, 32'h0000_0080);
    txn(1'b0, 32'h0000_0300, 2'b01, 1'b1, 32'h0, 4'h7, 2, 32'hFFFF_9234);
    txn(1'b0, 32'hFFFF_FFFE, 2'b11, 1'b0, 32'h0, 4'h9, 4, 32'hDDCC_BBAA);
    // Unaligned half store.
    txn(1'b1, 32'h0000_2001, 2'b01, 1'b0, 32'h0000_BEEF, 4'hA, 2, 32'h0);

    // Flush in cycle 2 of a word load.
    request(1'b0, 32'h0000_1000, 2'b10, 1'b0, 32'h0, 4'h2);
    chk("fl_c1_en", {31'd0, lsb_en}, 32'd1);
    tick();
    flush = 1'b1;
    chk("fl_c2_en", {31'd0, lsb_en}, 32'd1);
    chk("fl_c2_addr", lsb_addr, 32'h0000_1001);
    tick();
    flush = 1'b0;
    chk("fl_c3_en", {31'd0, lsb_en}, 32'd0);
    chk("fl_c3_ready", {31'd0, req_ready}, 32'd1);
    for (int k = 0; k < 4; k++) begin
      chk("fl_no_resp", {31'd0, resp_valid}, 32'd0);
      chk("fl_no_issue", {31'd0, lsb_en}, 32'd0);
      tick();
    end

    // Flush held through a word store and its DONE cycle.
    request(1'b1, 32'h0000_4000, 2'b10, 1'b0, 32'hCAFE_BABE, 4'hC);
    flush = 1'b1;
    chk("fs_b0", {lsb_en, lsb_wr, 22'd0, lsb_data}, {2'b11, 22'd0, 8'hBE});
    tick();
    chk("fs_b1", {lsb_en, lsb_wr, 22'd0, lsb_data}, {2'b11, 22'd0, 8'hBA});
    tick();
    chk("fs_b2", {lsb_en, lsb_wr, 22'd0, lsb_data}, {2'b11, 22'd0, 8'hFE});
    tick();
    chk("fs_b3", {lsb_en, lsb_wr, 22'd0, lsb_data}, {2'b11, 22'd0, 8'hCA});
    chk("fs_b3_addr", lsb_addr, 32'h0000_4003);
    tick();
    chk("fs_c5_resp", {31'd0, resp_valid}, 32'd0);
    tick();
    chk("fs_c6_resp", {31'd0, resp_valid}, 32'd1);
    chk("fs_c6_data", resp_data, 32'd0);
    chk("fs_c6_tag", {28'd0, resp_tag}, 32'hC);
    // Flush in IDLE blocks acceptance.
    req_valid = 1'b1; req_wr = 1'b0; req_addr = 32'h0000_1000; req_size = 2'b10;
    tick();
    chk("fi_ready", {31'd0, req_ready}, 32'd1);
    chk("fi_blocked", {31'd0, lsb_en}, 32'd0);
    tick();
    chk("fi_still_idle", {31'd0, req_ready}, 32'd1);
    flush = 1'b0;
    txn(1'b0, 32'h0000_1000, 2'b10, 1'b0, 32'h0, 4'h1, 4, 32'h4433_2211);

    // Reset asserted after two store bytes have gone out.
    request(1'b1, 32'h0000_5000, 2'b10, 1'b0, 32'h1234_5678, 4'hE);
    tick();
    tick();
    chk("rm_c3_en", {31'd0, lsb_en}, 32'd1);
    rst_in = 1'b1;
    #1;
    chk("rm_en", {31'd0, lsb_en}, 32'd0);
    chk("rm_ready", {31'd0, req_ready}, 32'd1);
    chk("rm_addr", lsb_addr, 32'd0);
    tick();
    rst_in = 1'b0;
    for (int k = 0; k < 6; k++) begin
      chk("rm_no_resp", {31'd0, resp_valid}, 32'd0);
      chk("rm_no_issue", {31'd0, lsb_en}, 32'd0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/data_mem_unit.md
DATA_MEM_UNIT -- requirements
Module: data_mem_unit

Interface
REQ-001 SHALL have parameter: TAG_W, 4, width of request/response tag.
REQ-002 SHALL have port: clk_in  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst_in  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have ports: req_valid input 1 request present; req_ready output 1 unit can accept.
REQ-005 SHALL have ports: req_wr input 1 (1=store); req_addr input 32 byte address; req_size input 2 (00 byte, 01 half, 10 word, 11 treated as word).
REQ-006 SHALL have ports: req_signed input 1 sign-extend load; req_wdata input 32 store data; req_tag input TAG_W.
REQ-007 SHALL have port: flush  input  1  abort in-progress load / block acceptance.
REQ-008 SHALL have ports: resp_valid output 1 one-cycle completion pulse; resp_data output 32; resp_tag output TAG_W.
REQ-009 SHALL have ports to memory controller LSB side: lsb_addr output 32, lsb_data output 8, lsb_wr output 1, lsb_en output 1, lsb_read_data input 8, lsb_valid input 1.

Function
REQ-010 SHALL implement states IDLE, ACCESS, DONE; req_ready = 1 only in IDLE.
REQ-011 SHALL accept a request on a rising edge where state=IDLE, req_valid=1, flush=0; latch addr, size, signed, wr, wdata, tag; N = 1/2/4 bytes per size; IDLE->ACCESS.
REQ-012 SHALL, in ACCESS, issue one byte per cycle for N consecutive cycles: lsb_en=1, lsb_addr=base+issue_cnt (mod 2^32), lsb_wr=latched wr, lsb_data=wdata byte[issue_cnt] (little-endian, byte 0 first).
REQ-013 SHALL drive lsb_en=0, lsb_wr=0, lsb_addr=0, lsb_data=0 whenever no byte is being issued.
REQ-014 SHALL count a returned byte on each lsb_valid=1 in ACCESS (one cycle after its issue); for loads capture lsb_read_data into result byte[recv_cnt].
REQ-015 SHALL go ACCESS->DONE on the edge where the Nth byte returns; DONE lasts one cycle with resp_valid=1, resp_tag=latched tag; DONE->IDLE.
REQ-016 SHALL, for loads, drive resp_data = assembled bytes zero-extended (req_signed=0) or sign-extended from bit 8N-1 (req_signed=1); for stores resp_data=0.
REQ-017 SHALL hold resp_valid=0 and resp_data=0 outside DONE.
REQ-018 Latency: request accepted in cycle 0 -> issues cycles 1..N -> resp_valid in cycle N+2; next acceptance no earlier than cycle N+3.
REQ-019 SHALL allow unaligned addresses; no alignment check, address increment wraps 0xFFFFFFFF->0x00000000.
REQ-020 SHALL, on flush=1 during a load in ACCESS, stop issuing from the next cycle, return to IDLE, and emit no resp_valid; a stray lsb_valid arriving in IDLE SHALL be ignored.
REQ-021 SHALL ignore flush during a store; the store completes all N bytes and pulses resp_valid.
REQ-022 SHALL ignore flush in DONE (response still issued); flush in IDLE only blocks acceptance.
REQ-023 SHALL reset issue_cnt and recv_cnt to 0 on each acceptance.

Reset
REQ-024 SHALL, while rst_in=1, immediately force state=IDLE, counters=0, req_ready=1, resp_valid=0, resp_data=0, resp_tag=0, lsb_en=0, lsb_wr=0, lsb_addr=0, lsb_data=0.
REQ-025 SHALL abandon any in-progress access (including a partially issued store) on reset, with no response.

Verification
REQ-026 Word load addr 0x1000, mem bytes 11,22,33,44 -> lsb_addr 0x1000..0x1003 cycles 1-4, resp_valid cycle 6, resp_data 0x44332211.
REQ-027 Byte load 0x80: signed -> resp_data 0xFFFFFF80; unsigned -> 0x00000080; half load bytes 0x34,0x92 signed -> 0xFFFF9234.
REQ-028 Half store 0xBEEF to 0x2001 -> cycle 1 addr 0x2001 data 0xEF wr=1, cycle 2 addr 0x2002 data 0xBE wr=1, resp_valid cycle 4, resp_data 0.
REQ-029 Word load 0xFFFFFFFE -> lsb_addr sequence 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000, 0x00000001.
REQ-030 Flush at cycle 2 of word load -> lsb_en=0 from cycle 3, no resp_valid, req_ready=1 cycle 3; flush during word store -> all 4 bytes written, resp_valid cycle 6.
REQ-031 rst_in asserted mid-store (after 2 bytes) -> lsb_en=0 and req_ready=1 immediately, no resp_valid after release.
